// File: rtl/typePack.sv
// Shared fetch-path types: instruction word, fetch FSM states, fetch constants.
// Pure declarations; no latency or flow control of its own.
// The {pc, inst} entry packs a fetched word with its address for buffering.
package typePack;

   typedef logic [31:0] instruction_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } ifetch_state_t;

   localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INST_BYTES      = 32'd4;

   typedef struct packed {
      logic [31:0]  pc;
      instruction_t inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count.
// Latency: a push is visible at the head one cycle later; pop acts on the current head.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module ifetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   input  logic                       clear,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing reads an entry before it has been written.
   always_ff @(posedge CLOCK) begin
      if (push_ok && !clear) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, issues word requests, buffers {pc,inst}; IFETCH_ALIGN_CHECK_EN adds MISALIGN/HALT.
// Latency: grant at n, rvalid at m>=n+1, INST_VALID at m+1.
// Backpressure: requests only while buffer credit covers every live in-flight word; redirect flushes.
module ifetch_ctrl
   import typePack::*;
#(
   parameter logic [31:0] RESET_PC        = IFETCH_RESET_PC,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic         CLOCK,
   input  logic         RESET,
   output logic         IMEM_REQ,
   output logic [31:0]  IMEM_ADDR,
   input  logic         IMEM_GNT,
   input  logic         IMEM_RVALID,
   input  logic [31:0]  IMEM_RDATA,
   input  logic         REDIRECT,
   input  logic [31:0]  REDIRECT_PC,
   output logic         INST_VALID,
   output instruction_t INST,
   output logic [31:0]  INST_PC,
   input  logic         INST_READY
`ifdef IFETCH_ALIGN_CHECK_EN
   ,
   output logic         MISALIGN
`endif
);

   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   ifetch_state_t state;
   ifetch_state_t state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   redirect_base;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_nxt;
   logic [OW-1:0] discard;
   logic [OW-1:0] discard_nxt;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          credit_ok;
   logic          grant;
   logic          push;
   logic          pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign redirect_base = REDIRECT_PC & ~32'h3;
   assign push_entry    = '{pc: resp_pc, inst: IMEM_RDATA};

   // Words already granted but not being discarded still need a buffer slot.
   assign credit_ok = (32'(outstanding) - 32'(discard) + 32'(fifo_count)) < 32'(FIFO_DEPTH);

   always_comb begin
      state_nxt       = state;
      IMEM_REQ        = 1'b0;
      grant           = 1'b0;
      push            = 1'b0;
      pop             = 1'b0;
      INST_VALID      = 1'b0;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;

      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
`ifdef IFETCH_ALIGN_CHECK_EN
      if (REDIRECT && (REDIRECT_PC[1:0] != 2'b00)) state_nxt = HALT;
`endif

      IMEM_REQ = (state == RUN) && !REDIRECT && credit_ok &&
                 (32'(outstanding) < 32'(MAX_OUTSTANDING));
      grant    = IMEM_REQ && IMEM_GNT;
      push     = IMEM_RVALID && !REDIRECT && (discard == '0) && (state != HALT);
      INST_VALID = !fifo_empty && (state != HALT);
      pop      = INST_VALID && INST_READY && !REDIRECT;

      if (grant && !IMEM_RVALID)      outstanding_nxt = outstanding + OW'(1);
      else if (!grant && IMEM_RVALID) outstanding_nxt = outstanding - OW'(1);

      // After a redirect every word still in flight belongs to the old stream.
      if (REDIRECT)                              discard_nxt = outstanding_nxt;
      else if (IMEM_RVALID && (discard != '0))   discard_nxt = discard - OW'(1);
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         if (REDIRECT) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
         end else begin
            if (grant) fetch_pc <= fetch_pc + INST_BYTES;
            if (push)  resp_pc  <= resp_pc + INST_BYTES;
         end
      end
   end

   ifetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .head_dat (head),
      .clear    (REDIRECT),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign IMEM_ADDR = fetch_pc;
   assign INST      = INST_VALID ? head.inst : '0;
   assign INST_PC   = INST_VALID ? head.pc   : '0;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign MISALIGN = (state == HALT);
`endif

   a_no_push_when_full: assert property (@(posedge CLOCK) disable iff (RESET)
      !(push && fifo_full));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized and directed bench for ifetch_ctrl against a queue-based reference model.
module tb_ifetch_ctrl;
   import typePack::*;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 2;
   localparam int          MAXO  = 2;

   logic         CLOCK = 1'b0;
   logic         RESET = 1'b1;
   logic         IMEM_REQ;
   logic [31:0]  IMEM_ADDR;
   logic         IMEM_GNT = 1'b0;
   logic         IMEM_RVALID = 1'b0;
   logic [31:0]  IMEM_RDATA = '0;
   logic         REDIRECT = 1'b0;
   logic [31:0]  REDIRECT_PC = '0;
   logic         INST_VALID;
   instruction_t INST;
   logic [31:0]  INST_PC;
   logic         INST_READY = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
   logic         MISALIGN;
`endif

   ifetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_GNT    (IMEM_GNT),
      .IMEM_RVALID (IMEM_RVALID),
      .IMEM_RDATA  (IMEM_RDATA),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .INST_VALID  (INST_VALID),
      .INST        (INST),
      .INST_PC     (INST_PC),
      .INST_READY  (INST_READY)
`ifdef IFETCH_ALIGN_CHECK_EN
      ,
      .MISALIGN    (MISALIGN)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   int checks = 0;
   int passes = 0;

   // Reference model: counters plus a queue standing in for the instruction buffer.
   bit          m_idle, m_halt;
   logic [31:0] m_fpc, m_rpc;
   int          m_out, m_disc;
   logic [63:0] m_q[$];

   // Memory model: in-order responses, each due a few cycles after its grant.
   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t pend[$];
   int    cyc = 0;
   int    last_due = 0;
   int    lat_min = 1, lat_max = 1;
   bit          rv;
   logic [31:0] rd;

   bit          e_req, e_valid;
   logic [31:0] e_addr, e_pc, e_inst;
   logic [31:0] dut_pc[$];
   logic [31:0] dut_inst[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      m_idle = 1'b1; m_halt = 1'b0;
      m_fpc = RPC; m_rpc = RPC;
      m_out = 0; m_disc = 0;
      m_q.delete(); pend.delete();
      last_due = 0;
   endtask

   task automatic drive(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
      @(negedge CLOCK);
      IMEM_GNT = gnt; INST_READY = rdy; REDIRECT = redir; REDIRECT_PC = rpc;
      rv = (pend.size() > 0) && (pend[0].due <= cyc);
      rd = rv ? mem_word(pend[0].addr) : $urandom;
      IMEM_RVALID = rv; IMEM_RDATA = rd;
      e_req   = !m_idle && !m_halt && !redir && (m_out < MAXO) &&
                ((m_out - m_disc) + m_q.size() < DEPTH);
      e_addr  = m_fpc;
      e_valid = !m_halt && (m_q.size() > 0);
      e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
      e_inst  = e_valid ? m_q[0][31:0]  : 32'h0;
      #1;
      if (INST_VALID && rdy && !redir) begin
         dut_pc.push_back(INST_PC);
         dut_inst.push_back(INST);
      end
   endtask

   task automatic advance();
      bit grant, pop;
      int due;
      grant = e_req && IMEM_GNT;
      pop   = e_valid && INST_READY && !REDIRECT;
      if (pop) void'(m_q.pop_front());
      if (grant) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due < last_due) due = last_due;
         last_due = due;
         pend.push_back('{m_fpc, due});
         m_fpc = m_fpc + 32'd4;
         m_out++;
      end
      if (rv) begin
         void'(pend.pop_front());
         m_out--;
         if (!REDIRECT && !m_halt) begin
            if (m_disc > 0) m_disc--;
            else begin
               m_q.push_back({m_rpc, rd});
               m_rpc = m_rpc + 32'd4;
            end
         end
      end
      if (REDIRECT) begin
         m_q.delete();
         m_fpc  = {REDIRECT_PC[31:2], 2'b00};
         m_rpc  = {REDIRECT_PC[31:2], 2'b00};
         m_disc = m_out;
`ifdef IFETCH_ALIGN_CHECK_EN
         if (REDIRECT_PC[1:0] != 2'b00) m_halt = 1'b1;
`endif
      end
      m_idle = 1'b0;
      cyc++;
      @(posedge CLOCK);
   endtask

   task automatic test_reset();
      @(negedge CLOCK);
      IMEM_GNT = 1'b0; INST_READY = 1'b0; REDIRECT = 1'b0; IMEM_RVALID = 1'b0;
      RESET = 1'b1;
      #1;
      checks++;
      if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== RPC || INST_VALID !== 1'b0 ||
          INST !== 32'h0 || INST_PC !== 32'h0)
         $display("FAIL reset req=%b addr=%h valid=%b inst=%h pc=%h, required 0 %h 0 0 0",
                  IMEM_REQ, IMEM_ADDR, INST_VALID, INST, INST_PC, RPC);
      else passes++;
`ifdef IFETCH_ALIGN_CHECK_EN
      checks++;
      if (MISALIGN !== 1'b0) $display("FAIL reset_misalign got %b required 0", MISALIGN);
      else passes++;
`endif
      @(posedge CLOCK);
      @(posedge CLOCK);
      #1 RESET = 1'b0;
      model_reset();
   endtask

   task automatic test_stream();
      int ph_n[5] = '{12, 8, 10, 3, 10};
      bit ph_g[5] = '{1, 1, 1, 0, 1};
      bit ph_r[5] = '{1, 0, 1, 1, 1};
      dut_pc.delete(); dut_inst.delete();
      lat_min = 1; lat_max = 1;
      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < ph_n[p]; i++) begin
            drive(ph_g[p], ph_r[p], 1'b0, 32'h0);
            checks++;
            if (IMEM_REQ !== e_req || IMEM_ADDR !== e_addr || INST_VALID !== e_valid ||
                (e_valid && (INST_PC !== e_pc || INST !== e_inst)))
               $display("FAIL stream cyc=%0d req=%b/%b addr=%h/%h valid=%b/%b pc=%h/%h inst=%h/%h (got/required)",
                        cyc, IMEM_REQ, e_req, IMEM_ADDR, e_addr, INST_VALID, e_valid,
                        INST_PC, e_pc, INST, e_inst);
            else passes++;
            if (p == 1 && i == ph_n[p] - 1) begin
               checks++;
               if (IMEM_REQ !== 1'b0 || INST_VALID !== 1'b1)
                  $display("FAIL ready_stall req=%b valid=%b required 0 1", IMEM_REQ, INST_VALID);
               else passes++;
            end
            advance();
         end
      end
      checks++;
      if (dut_pc.size() < 15) $display("FAIL stream_count got %0d required >=15", dut_pc.size());
      else passes++;
      for (int k = 0; k < dut_pc.size(); k++) begin
         checks++;
         if (dut_pc[k] !== RPC + 32'(4 * k) || dut_inst[k] !== mem_word(RPC + 32'(4 * k)))
            $display("FAIL stream_seq idx=%0d pc=%h inst=%h required %h %h", k, dut_pc[k],
                     dut_inst[k], RPC + 32'(4 * k), mem_word(RPC + 32'(4 * k)));
         else passes++;
      end
   endtask

   task automatic test_redirect();
      int          r_n[11]   = '{4, 1, 12, 3, 1, 1, 10, 1, 10, 1, 12};
      bit          r_red[11] = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0};
      logic [31:0] r_pc[11]  = '{0, 32'h200, 0, 0, 32'h280, 32'h300, 0, 32'hFFFF_FFFC, 0, 32'h202, 0};
      int          r_lat[11] = '{2, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1};
      int          mark[11];
      int          ei[5];
      logic [31:0] ep[5];
      dut_pc.delete(); dut_inst.delete();
      for (int r = 0; r < 11; r++) begin
         mark[r] = dut_pc.size();
         lat_min = r_lat[r]; lat_max = r_lat[r];
         for (int i = 0; i < r_n[r]; i++) begin
            drive(1'b1, 1'b1, r_red[r], r_pc[r]);
            checks++;
            if (IMEM_REQ !== e_req || IMEM_ADDR !== e_addr || INST_VALID !== e_valid ||
                (e_valid && (INST_PC !== e_pc || INST !== e_inst)))
               $display("FAIL redirect cyc=%0d req=%b/%b addr=%h/%h valid=%b/%b pc=%h/%h inst=%h/%h (got/required)",
                        cyc, IMEM_REQ, e_req, IMEM_ADDR, e_addr, INST_VALID, e_valid,
                        INST_PC, e_pc, INST, e_inst);
            else passes++;
            advance();
         end
      end
      ei = '{mark[1], mark[5], mark[7], mark[7] + 1, mark[9]};
      ep = '{32'h200, 32'h300, 32'hFFFF_FFFC, 32'h0000_0000, 32'h200};
`ifdef IFETCH_ALIGN_CHECK_EN
      for (int k = 0; k < 4; k++) begin
`else
      for (int k = 0; k < 5; k++) begin
`endif
         checks++;
         if (dut_pc.size() <= ei[k])
            $display("FAIL redirect_first k=%0d delivered %0d required more than %0d", k, dut_pc.size(), ei[k]);
         else if (dut_pc[ei[k]] !== ep[k] || dut_inst[ei[k]] !== mem_word(ep[k]))
            $display("FAIL redirect_first k=%0d pc=%h inst=%h required %h %h", k, dut_pc[ei[k]],
                     dut_inst[ei[k]], ep[k], mem_word(ep[k]));
         else passes++;
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      checks++;
      if (MISALIGN !== 1'b1 || IMEM_REQ !== 1'b0 || INST_VALID !== 1'b0 || dut_pc.size() != mark[9])
         $display("FAIL halt misalign=%b req=%b valid=%b delivered=%0d required 1 0 0 %0d",
                  MISALIGN, IMEM_REQ, INST_VALID, dut_pc.size(), mark[9]);
      else passes++;
`endif
   endtask

   task automatic test_random();
      bit          g, r, d;
      logic [31:0] p;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         g = ($urandom % 4) != 0;
         r = ($urandom % 3) != 0;
         d = ($urandom % 25) == 0;
`ifdef IFETCH_ALIGN_CHECK_EN
         p = $urandom & 32'hFFFF_FFFC;
`else
         p = $urandom;
`endif
         drive(g, r, d, p);
         checks++;
         if (IMEM_REQ !== e_req || IMEM_ADDR !== e_addr || INST_VALID !== e_valid ||
             (e_valid && (INST_PC !== e_pc || INST !== e_inst)))
            $display("FAIL random cyc=%0d req=%b/%b addr=%h/%h valid=%b/%b pc=%h/%h inst=%h/%h (got/required)",
                     cyc, IMEM_REQ, e_req, IMEM_ADDR, e_addr, INST_VALID, e_valid,
                     INST_PC, e_pc, INST, e_inst);
         else passes++;
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_redirect();
      test_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
